// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with valid/ready handshake, flush and
// saturating stall counter. Define PIPE_REG_SKID_EN for a 2-entry skid with registered in_ready.
module pipe_stage_reg #(
    parameter int              WIDTH     = 71,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_accept;
    logic             w_emit;
    logic             w_stall;

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;
    assign w_accept  = in_valid & in_ready;
    assign w_emit    = r_main_valid & out_ready;
    assign w_stall   = r_main_valid & ~out_ready;

`ifdef PIPE_REG_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    // Ready depends only on the skid flop, so no combinational path from out_ready.
    assign in_ready = ~r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= RESET_VAL;
            r_skid_valid <= 1'b0;
            r_skid_data  <= RESET_VAL;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_emit) begin
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept && (!r_main_valid || w_emit)) begin
            r_main_data  <= in_data;
            r_main_valid <= 1'b1;
        end else if (w_accept) begin
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
        end else if (w_emit) begin
            r_main_valid <= 1'b0;
        end
    end
`else
    assign in_ready = ~r_main_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= RESET_VAL;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main_data  <= in_data;
            r_main_valid <= 1'b1;
        end else if (w_emit) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

    // Counter keeps running through flush; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model plus directed literals.
module tb_pipe_stage_reg;

    localparam int         W    = 8;
    localparam int         CW   = 4;
    localparam logic [7:0] RV   = 8'hC3;
    localparam int         MAXC = 15;
`ifdef PIPE_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] q[$];
    int mcnt = 0;

    pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of capacity 1 or 2, checked at every falling edge.
    initial begin
        bit acc, emi;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                mcnt = 0;
                chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
                chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
                chk("rst_out_data",  {24'd0, out_data},  {24'd0, RV});
                chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
            end else begin
                chk("in_ready",  {31'd0, in_ready},  {31'd0, m_in_ready()});
                chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
                if (q.size() > 0) chk("out_data", {24'd0, out_data}, {24'd0, q[0]});
                chk("stall_cnt", {28'd0, stall_cnt}, mcnt);
                if (!SKID && q.size() > 1) chk("occupancy", q.size(), 1);
                acc = in_valid && m_in_ready();
                emi = (q.size() > 0) && out_ready;
                if (q.size() > 0 && !out_ready && mcnt < MAXC) mcnt++;
                if (flush) q.delete();
                else begin
                    if (emi) void'(q.pop_front());
                    if (acc) q.push_back(in_data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("init_out_data", {24'd0, out_data}, {24'd0, RV});
        tick(); tick();
        rst = 1'b0;
        tick();

        // Streaming
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        tick(); chk("stream0", {24'd0, out_data}, 32'h11);
        in_data = 8'h22;
        tick(); chk("stream1", {24'd0, out_data}, 32'h22);
        in_data = 8'h33;
        tick(); chk("stream2", {24'd0, out_data}, 32'h33);
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick(); chk("stream_empty", {31'd0, out_valid}, 32'd0);
        chk("stream_cnt", {28'd0, stall_cnt}, 32'd0);

        // Back-pressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
        tick(); chk("bp_main", {24'd0, out_data}, 32'h0A);
        if (SKID) begin
            in_data = 8'h0B;
            tick(); chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
            in_data = 8'h0C;
            tick(); chk("bp_hold", {24'd0, out_data}, 32'h0A);
            out_ready = 1'b1;
            tick(); chk("bp_out_b", {24'd0, out_data}, 32'h0B);
            chk("bp_ready_up", {31'd0, in_ready}, 32'd1);
            tick(); chk("bp_out_c", {24'd0, out_data}, 32'h0C);
        end else begin
            in_data = 8'h0B;
            chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
            tick(); chk("bp_hold", {24'd0, out_data}, 32'h0A);
            out_ready = 1'b1;
            tick(); chk("bp_out_b", {24'd0, out_data}, 32'h0B);
            in_data = 8'h0C;
            tick(); chk("bp_out_c", {24'd0, out_data}, 32'h0C);
        end
        in_valid = 1'b0;
        tick(); chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Flush during a stall
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
        tick(); in_data = 8'h02;
        tick(); in_data = 8'h05; flush = 1'b1;
        tick(); flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        tick(); chk("flush_no5", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream, asserted between edges
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        tick(); in_valid = 1'b0;
        tick(); chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data",  {24'd0, out_data},  {24'd0, RV});
        chk("arst_cnt",   {28'd0, stall_cnt}, 32'd0);
        chk("arst_ready", {31'd0, in_ready},  32'd1);
        tick(); rst = 1'b0;
        tick();

        // Counter saturation
        in_valid = 1'b1; in_data = 8'h09;
        tick(); in_valid = 1'b0;
        repeat (20) tick();
        chk("sat_15", {28'd0, stall_cnt}, 32'd15);
        tick(); chk("sat_hold", {28'd0, stall_cnt}, 32'd15);
        out_ready = 1'b1;
        tick(); chk("sat_after_emit", {28'd0, stall_cnt}, 32'd15);

        // Async reset to restart the counter for the random phase
        #2 rst = 1'b1;
        tick(); rst = 1'b0;
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = SKID ? ($urandom_range(0, 2) == 0) : i[0];
            flush     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                tick(); rst = 1'b0;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0; flush = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register that replaces the fixed, free-running inter-stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload and adds a valid/ready handshake, a synchronous flush for hazard and branch recovery, and a saturating back-pressure counter. An optional skid entry registers `in_ready`, which breaks the combinational ready path between stages.

## Interface
Parameters:
- `WIDTH`, 71, payload width in bits; 71 packs the MEM/WB bundle: RegWrite 1, MemtoReg 1, ReadData 32, ALUOut 32, WriteReg 5.
- `RESET_VAL`, `{WIDTH{1'b0}}`, value loaded into the payload registers on reset.
- `CNT_W`, 16, width of the stall counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid`  in  1  upstream stage presents a payload.
- `in_ready`  out  1  this stage can accept the payload.
- `in_data`  in  WIDTH  upstream payload.
- `flush`  in  1  synchronous squash of all held entries.
- `out_valid`  out  1  downstream payload is valid.
- `out_ready`  in  1  downstream stage consumes the payload.
- `out_data`  out  WIDTH  held payload.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid & !out_ready`.

## Operation
Transfer events:
- `accept = in_valid & in_ready`.
- `emit = out_valid & out_ready`.

Storage and outputs:
- Storage is a main entry (`main_valid`, `main_data`), plus a skid entry (`skid_valid`, `skid_data`) when `PIPE_REG_SKID_EN` is defined.
- `out_valid = main_valid`.
- `out_data = main_data`.

Priority at each rising edge, highest first:
1. `rst`: asserting it clears both valids, loads `RESET_VAL` into both data registers and zeroes `stall_cnt`. This takes effect immediately, mid-transfer included. Any held payload is lost.
2. `flush`: clears `main_valid` and `skid_valid`. Data registers hold their value. Input presented this cycle is dropped even if `accept` is true. `stall_cnt` still updates.
3. Skid entry occupied: on `emit`, `main_data <= skid_data` and `skid_valid <= 0`. No `accept` is possible, because `in_ready` is 0.
4. Otherwise:
   - `accept & (!main_valid | emit)` → `main_data <= in_data`, `main_valid <= 1`.
   - `accept & main_valid & !emit` → `skid_data <= in_data`, `skid_valid <= 1`.
   - `!accept & emit` → `main_valid <= 0`.
   - Neither event → hold.

Stall counter:
- Increments by 1 on every cycle with `out_valid & !out_ready`.
- Saturates at `2^CNT_W-1`; no wrap.
- Cleared only by `rst`.

General rules:
- Payload is opaque and is never modified.
- Ordering is strictly FIFO; no entry is duplicated or lost except through `flush` or `rst`.

## Timing
- Latency: an accepted payload appears on `out_data` with `out_valid = 1` one cycle after the accepting edge.
- Throughput: one transfer per cycle while `out_ready` is held at 1.
- Reset values: `out_valid = 0`, `out_data = RESET_VAL`, `stall_cnt = 0`, `in_ready = 1`.
- With skid: `in_ready = !skid_valid`, driven directly from a flop.
  - Capacity is 2 entries.
  - `in_ready` falls in the cycle after an accept that coincides with a stalled main entry.
  - `in_ready` rises in the cycle after the skid entry drains.
- Simultaneous `accept` and `emit` while the main entry is full: the main entry is replaced in place and the skid entry stays empty.
- Simultaneous `flush` and `accept`: the stage is empty after the edge.
- Simultaneous `flush` and `emit`: downstream sees that payload as consumed in that cycle; the stage is empty after the edge.

## Configuration
Macro: `PIPE_REG_SKID_EN`.
- Defined: 2-entry skid operation as described above; `in_ready` is registered.
- Undefined:
  - No skid storage; capacity is 1.
  - `in_ready = !main_valid | out_ready`, combinational from `out_ready`.
  - Rule 3 and the skid load of rule 4 do not exist.
  - All other behaviour, the reset values and the 1-cycle latency are identical.

## Test plan
- Reset mid-stream: with `main_valid = 1`, assert `rst` between clock edges → `out_valid` drops to 0, `out_data = 0` and `stall_cnt = 0` immediately; `in_ready = 1`.
- Streaming: `out_ready = 1`, inputs 0x11, 0x22, 0x33 on consecutive cycles → the same values appear on `out_data` one cycle later each; `stall_cnt` stays 0.
- Back-pressure (skid enabled): `out_ready = 0`, feed 0xA, 0xB, 0xC →
  - 0xA is held in the main entry, 0xB in the skid entry.
  - `in_ready` goes 0 on the third cycle, so 0xC is not accepted.
  - Then raise `out_ready` → outputs 0xA, 0xB, 0xC in order with no loss.
- Flush during a stall: 2 entries held, pulse `flush` together with `in_valid` carrying 0x5 → next cycle `out_valid = 0` and `in_ready = 1`; 0x5 never appears.
- Counter saturation: with `CNT_W = 4`, hold `out_valid = 1` and `out_ready = 0` for 20 cycles → `stall_cnt` reads 15 and holds at 15.
- Skid disabled build: `out_ready` toggles 1/0 with the input valid continuously →
  - `in_ready` equals `!out_valid | out_ready` combinationally in every cycle.
  - No more than one entry is ever held.
